// File: rtl/sbinit_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sbinit_seq_ctrl
//  Purpose  : LTSM SBINIT-phase sequencer. The sequencer runs three exchanges
//             with the link partner in order:
//               1. out_of_reset
//               2. done_req
//               3. done_resp
//             It sends each message to the sideband encoder over a
//             valid/ready handshake. It consumes decoded RX message numbers
//             and raises done_o when SBINIT is complete.
//  Config   : SBINIT_TIMEOUT_EN (optional define). When defined, a cycle
//             counter starts on leaving IDLE and forces ERROR after
//             TIMEOUT_CYCLES. When undefined, there is no counter and
//             error_o is tied to 0.
//  Ports    : clk         single clock
//             rst_n       synchronous active-low reset
//             start_i     level; run SBINIT, deassert to return to IDLE
//             tx_valid_o  message offered to SB encoder
//             tx_msg_o    SB_msgNum_t of offered message
//             tx_ready_i  encoder accepts when tx_valid_o & tx_ready_i
//             rx_valid_i  one-cycle strobe, decoded message present
//             rx_msg_i    SB_msgNum_t from decoder
//             done_o      SBINIT complete
//             error_o     SBINIT timed out
//             state_o     current state encoding (debug)
//  Revision : 1.0  initial release
// ============================================================================
module sbinit_seq_ctrl #(
    parameter int RESEND_INTERVAL = 16,
    parameter int TIMEOUT_CYCLES  = 8000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       tx_valid_o,
    output logic [2:0] tx_msg_o,
    input  logic       tx_ready_i,
    input  logic       rx_valid_i,
    input  logic [2:0] rx_msg_i,
    output logic       done_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OOR   = 3'd1;
    localparam logic [2:0] ST_XCHG  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    // SB_msgNum_t values used by this phase. CODEX_ERROR (3'b111) and any
    // other code simply match none of these and are ignored.
    localparam logic [2:0] MSG_OOR       = 3'b000;
    localparam logic [2:0] MSG_DONE_REQ  = 3'b001;
    localparam logic [2:0] MSG_DONE_RESP = 3'b010;

    localparam int          RW          = $clog2(RESEND_INTERVAL + 1);
    localparam logic [RW-1:0] RESEND_LAST = RW'(RESEND_INTERVAL);

    logic [2:0]    state, state_n;
    logic          tx_valid_n;
    logic [2:0]    tx_msg_n;
    logic [RW-1:0] gap_cnt, gap_cnt_n;

    logic oor_rcvd,  oor_rcvd_n;
    logic oor_sent,  oor_sent_n;
    logic req_sent,  req_sent_n;
    logic resp_sent, resp_sent_n;
    logic req_rcvd,  req_rcvd_n;
    logic resp_rcvd, resp_rcvd_n;
    logic resp_pend, resp_pend_n;

    logic accept;
    logic rx_oor, rx_req, rx_resp;
    logic tmo_hit;

    assign accept  = tx_valid_o & tx_ready_i;
    assign rx_oor  = rx_valid_i & (rx_msg_i == MSG_OOR);
    assign rx_req  = rx_valid_i & (rx_msg_i == MSG_DONE_REQ);
    assign rx_resp = rx_valid_i & (rx_msg_i == MSG_DONE_RESP);
    assign state_o = state;

    always_comb begin
        state_n     = state;
        tx_valid_n  = tx_valid_o;
        tx_msg_n    = tx_msg_o;
        gap_cnt_n   = gap_cnt;
        oor_rcvd_n  = oor_rcvd;
        oor_sent_n  = oor_sent;
        req_sent_n  = req_sent;
        resp_sent_n = resp_sent;
        req_rcvd_n  = req_rcvd;
        resp_rcvd_n = resp_rcvd;
        resp_pend_n = resp_pend;

        case (state)
            ST_IDLE: begin
                tx_valid_n  = 1'b0;
                tx_msg_n    = MSG_OOR;
                gap_cnt_n   = '0;
                oor_rcvd_n  = 1'b0;
                oor_sent_n  = 1'b0;
                req_sent_n  = 1'b0;
                resp_sent_n = 1'b0;
                req_rcvd_n  = 1'b0;
                resp_rcvd_n = 1'b0;
                resp_pend_n = 1'b0;
                if (start_i) begin
                    state_n    = ST_OOR;
                    tx_valid_n = 1'b1;
                end
            end

            ST_OOR: begin
                if (rx_oor) begin
                    oor_rcvd_n = 1'b1;
                end
                // An early done_req from the partner is remembered so the
                // response is owed as soon as XCHG starts.
                if (rx_req) begin
                    req_rcvd_n  = 1'b1;
                    resp_pend_n = 1'b1;
                end
                if (accept) begin
                    oor_sent_n = 1'b1;
                    tx_valid_n = 1'b0;
                    gap_cnt_n  = '0;
                end else if (!tx_valid_o) begin
                    // Count idle cycles since the last acceptance; the offer
                    // returns once RESEND_INTERVAL idle cycles have elapsed.
                    if (gap_cnt != RESEND_LAST) begin
                        gap_cnt_n = gap_cnt + RW'(1);
                    end
                    if (gap_cnt_n == RESEND_LAST) begin
                        tx_valid_n = 1'b1;
                        tx_msg_n   = MSG_OOR;
                    end
                end
                if (oor_rcvd_n && oor_sent_n && (!tx_valid_o || accept)) begin
                    state_n    = ST_XCHG;
                    tx_valid_n = 1'b1;
                    tx_msg_n   = resp_pend_n ? MSG_DONE_RESP : MSG_DONE_REQ;
                end
            end

            ST_XCHG: begin
                // A repeated done_req while a response is still owed
                // collapses into that single response.
                if (rx_req) begin
                    req_rcvd_n = 1'b1;
                    if (!resp_pend) begin
                        resp_pend_n = 1'b1;
                    end
                end
                // A done_resp only answers our own request once that
                // request has actually been delivered.
                if (rx_resp && req_sent) begin
                    resp_rcvd_n = 1'b1;
                end
                if (accept) begin
                    if (tx_msg_o == MSG_DONE_RESP) begin
                        resp_pend_n = 1'b0;
                        resp_sent_n = 1'b1;
                    end else if (tx_msg_o == MSG_DONE_REQ) begin
                        req_sent_n = 1'b1;
                    end
                end
                // A new offer is chosen only when the handshake is free, so
                // an offered message never changes before acceptance.
                if (!tx_valid_o || accept) begin
                    if (resp_pend_n) begin
                        tx_valid_n = 1'b1;
                        tx_msg_n   = MSG_DONE_RESP;
                    end else if (!req_sent_n) begin
                        tx_valid_n = 1'b1;
                        tx_msg_n   = MSG_DONE_REQ;
                    end else begin
                        tx_valid_n = 1'b0;
                    end
                end
                if (req_sent_n && resp_sent_n && req_rcvd_n && resp_rcvd_n &&
                    (!tx_valid_o || accept)) begin
                    state_n    = ST_DONE;
                    tx_valid_n = 1'b0;
                end
            end

            ST_DONE, ST_ERROR: begin
                tx_valid_n = 1'b0;
            end

            default: begin
                state_n    = ST_IDLE;
                tx_valid_n = 1'b0;
            end
        endcase

        // Timeout overrides whatever the exchange logic decided this cycle.
        if (tmo_hit) begin
            state_n    = ST_ERROR;
            tx_valid_n = 1'b0;
        end

        // Dropping start_i abandons the sequence from any active state.
        if (state != ST_IDLE && !start_i) begin
            state_n     = ST_IDLE;
            tx_valid_n  = 1'b0;
            tx_msg_n    = MSG_OOR;
            gap_cnt_n   = '0;
            oor_rcvd_n  = 1'b0;
            oor_sent_n  = 1'b0;
            req_sent_n  = 1'b0;
            resp_sent_n = 1'b0;
            req_rcvd_n  = 1'b0;
            resp_rcvd_n = 1'b0;
            resp_pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx_valid_o <= 1'b0;
            tx_msg_o   <= MSG_OOR;
            done_o     <= 1'b0;
            gap_cnt    <= '0;
            oor_rcvd   <= 1'b0;
            oor_sent   <= 1'b0;
            req_sent   <= 1'b0;
            resp_sent  <= 1'b0;
            req_rcvd   <= 1'b0;
            resp_rcvd  <= 1'b0;
            resp_pend  <= 1'b0;
        end else begin
            state      <= state_n;
            tx_valid_o <= tx_valid_n;
            tx_msg_o   <= tx_msg_n;
            done_o     <= (state_n == ST_DONE);
            gap_cnt    <= gap_cnt_n;
            oor_rcvd   <= oor_rcvd_n;
            oor_sent   <= oor_sent_n;
            req_sent   <= req_sent_n;
            resp_sent  <= resp_sent_n;
            req_rcvd   <= req_rcvd_n;
            resp_rcvd  <= resp_rcvd_n;
            resp_pend  <= resp_pend_n;
        end
    end

`ifdef SBINIT_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_inc;
    logic          tmo_active;

    assign tmo_active = (state == ST_OOR) || (state == ST_XCHG);
    assign tmo_inc    = tmo_cnt + TW'(1);
    // Firing on the incremented value puts error_o high exactly
    // TIMEOUT_CYCLES clock edges after the IDLE exit.
    assign tmo_hit    = tmo_active && (tmo_inc == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            error_o <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_active && (tmo_cnt != TMO_LAST)) begin
                tmo_cnt <= tmo_inc;
            end
            error_o <= (state_n == ST_ERROR);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign error_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbinit_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbinit_seq_ctrl
//  Purpose  : Self-checking bench for sbinit_seq_ctrl. Directed scenarios and
//             randomized traffic are compared cycle by cycle against a
//             behavioural model of the SBINIT rules. Timeout behaviour is
//             exercised when SBINIT_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sbinit_seq_ctrl;

    localparam int RESEND = 16;
`ifdef SBINIT_TIMEOUT_EN
    localparam int TMO    = 100;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 8000;
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_OOR  = 3'd1;
    localparam logic [2:0] P_XCHG = 3'd2;
    localparam logic [2:0] P_DONE = 3'd3;
    localparam logic [2:0] P_ERR  = 3'd4;

    localparam logic [2:0] M_OOR  = 3'b000;
    localparam logic [2:0] M_REQ  = 3'b001;
    localparam logic [2:0] M_RESP = 3'b010;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [2:0] rx_msg   = 3'b000;
    logic       tx_valid;
    logic [2:0] tx_msg;
    logic       done;
    logic       error;
    logic [2:0] state;

    always #5 clk = ~clk;

    sbinit_seq_ctrl #(
        .RESEND_INTERVAL (RESEND),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .tx_valid_o (tx_valid),
        .tx_msg_o   (tx_msg),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_msg_i   (rx_msg),
        .done_o     (done),
        .error_o    (error),
        .state_o    (state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase, current offer, and the obligations/facts the
    // rules talk about.
    logic [2:0] m_phase;
    bit         m_valid;
    logic [2:0] m_msg;
    bit         m_done, m_err;
    bit         m_heard_oor, m_sent_oor, m_sent_req, m_sent_resp;
    bit         m_heard_req, m_heard_resp, m_owe_resp;
    int         m_idle_left, m_since_start;

    logic [2:0] acc_log[$];
    int         acc_cyc[$];

    task automatic model_clear();
        m_phase = P_IDLE; m_valid = 0; m_msg = M_OOR; m_done = 0; m_err = 0;
        m_heard_oor = 0; m_sent_oor = 0; m_sent_req = 0; m_sent_resp = 0;
        m_heard_req = 0; m_heard_resp = 0; m_owe_resp = 0;
        m_idle_left = 0; m_since_start = 0;
    endtask

    task automatic model_pick_offer();
        if (m_owe_resp) begin
            m_valid = 1; m_msg = M_RESP;
        end else if (!m_sent_req) begin
            m_valid = 1; m_msg = M_REQ;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic model_step();
        bit took, busy, h_oor, h_req, h_resp, owed_before, req_before;
        took   = m_valid && tx_ready;
        busy   = m_valid && !tx_ready;
        h_oor  = rx_valid && (rx_msg == M_OOR);
        h_req  = rx_valid && (rx_msg == M_REQ);
        h_resp = rx_valid && (rx_msg == M_RESP);
        if (!rst_n || (m_phase != P_IDLE && !start)) begin
            model_clear();
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (start) begin
                    m_phase = P_OOR; m_valid = 1; m_msg = M_OOR; m_since_start = 0;
                end
            end
            P_OOR, P_XCHG: begin
                m_since_start++;
                if (TMO_EN && m_since_start == TMO) begin
                    m_phase = P_ERR; m_valid = 0; m_err = 1;
                end else if (m_phase == P_OOR) begin
                    if (h_oor) m_heard_oor = 1;
                    if (h_req) begin m_heard_req = 1; m_owe_resp = 1; end
                    if (took) begin
                        m_sent_oor = 1; m_valid = 0; m_idle_left = RESEND;
                    end else if (!m_valid) begin
                        m_idle_left--;
                        if (m_idle_left == 0) begin m_valid = 1; m_msg = M_OOR; end
                    end
                    if (m_heard_oor && m_sent_oor && !busy) begin
                        m_phase = P_XCHG;
                        model_pick_offer();
                    end
                end else begin
                    owed_before = m_owe_resp;
                    req_before  = m_sent_req;
                    if (h_req) begin m_heard_req = 1; if (!owed_before) m_owe_resp = 1; end
                    if (h_resp && req_before) m_heard_resp = 1;
                    if (took && m_msg == M_RESP) begin m_owe_resp = 0; m_sent_resp = 1; end
                    if (took && m_msg == M_REQ) m_sent_req = 1;
                    if (!busy) model_pick_offer();
                    if (m_sent_req && m_sent_resp && m_heard_req && m_heard_resp && !busy) begin
                        m_phase = P_DONE; m_valid = 0; m_done = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [8:0] dut_vec();
        return {state, tx_valid, (tx_valid ? tx_msg : 3'b000), done, error};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_phase, m_valid, (m_valid ? m_msg : 3'b000), m_done, m_err};
    endfunction

    task automatic tick();
        if (tx_valid === 1'b1 && tx_ready) begin
            acc_log.push_back(tx_msg);
            acc_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rx_pulse(input logic [2:0] msg);
        rx_valid = 1; rx_msg = msg;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1; tx_ready = 1;
        tick(); tick();
        total++; if (state !== 3'd0)   begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_msg !== 3'b000) begin bad++; $display("FAIL reset_tx_msg got=%b exp=000", tx_msg); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (error !== 1'b0)    begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
        start = 0; rst_n = 1;
        tick();
        total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_happy();
        acc_log.delete();
        start = 1; tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL happy_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: rx_pulse(M_OOR);
                2: rx_pulse(M_REQ);
                4: rx_pulse(M_RESP);
                default: rx_valid = 0;
            endcase
            tick();
            rx_valid = 0;
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL happy_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        total++;
        if (acc_log.size() != 3 || {acc_log[0], acc_log[1], acc_log[2]} !== 9'b000_001_010) begin
            bad++; $display("FAIL happy_tx_seq got_count=%0d exp_seq=000,001,010", acc_log.size());
        end
        total++; if (state !== P_DONE || done !== 1'b1) begin bad++; $display("FAIL happy_done got state=%0d done=%b exp state=3 done=1", state, done); end
        start = 0;
        tick();
        total++; if (state !== P_IDLE || done !== 1'b0) begin bad++; $display("FAIL happy_idle got state=%0d done=%b exp state=0 done=0", state, done); end
    endtask

    task automatic test_resend();
        acc_cyc.delete();
        start = 1; tx_ready = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL resend_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        total++; if (acc_cyc.size() != 4) begin bad++; $display("FAIL resend_count got=%0d exp=4", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != RESEND + 1) begin
                bad++; $display("FAIL resend_gap got=%0d exp=%0d", acc_cyc[i] - acc_cyc[i-1], RESEND + 1);
            end
        end
        rx_pulse(M_OOR);
        tick();
        rx_valid = 0;
        total++; if (state !== P_XCHG || tx_valid !== 1'b1 || tx_msg !== M_REQ) begin
            bad++; $display("FAIL resend_to_xchg got state=%0d valid=%b msg=%b exp 2/1/001", state, tx_valid, tx_msg);
        end
        start = 0; tick();
    endtask

    task automatic test_backpressure();
        start = 1; tx_ready = 1;
        tick(); tick(); tick();
        rx_pulse(M_OOR); tx_ready = 0;
        tick();
        rx_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) rx_pulse(M_REQ);
            tick();
            rx_valid = 0;
            total++; if (tx_valid !== 1'b1 || tx_msg !== M_REQ) begin
                bad++; $display("FAIL bp_hold cyc=%0d got valid=%b msg=%b exp 1/001", cyc, tx_valid, tx_msg);
            end
        end
        tx_ready = 1;
        tick();
        total++; if (state !== P_XCHG || tx_valid !== 1'b1 || tx_msg !== M_RESP) begin
            bad++; $display("FAIL bp_next got state=%0d valid=%b msg=%b exp 2/1/010", state, tx_valid, tx_msg);
        end
        total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL bp_model got=%h exp=%h", dut_vec(), exp_vec()); end
        start = 0; tick();
    endtask

    task automatic test_ordering();
        start = 1; tx_ready = 1;
        tick(); tick(); tick();
        for (int s = 0; s < 8; s++) begin
            case (s)
                0: begin rx_pulse(M_OOR); tx_ready = 0; end
                1: rx_pulse(M_RESP);
                2: tx_ready = 1;
                3: rx_pulse(M_REQ);
                default: ;
            endcase
            tick();
            rx_valid = 0;
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL order_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        total++; if (state !== P_XCHG || done !== 1'b0) begin
            bad++; $display("FAIL order_early_resp got state=%0d done=%b exp state=2 done=0", state, done);
        end
        rx_pulse(M_RESP);
        tick();
        rx_valid = 0;
        tick();
        total++; if (state !== P_DONE || done !== 1'b1) begin
            bad++; $display("FAIL order_done got state=%0d done=%b exp state=3 done=1", state, done);
        end
        start = 0; tick();
    endtask

    task automatic test_abort();
        start = 1; tx_ready = 1;
        tick(); tick();
        rx_pulse(M_REQ); tick();
        rx_pulse(M_OOR); tx_ready = 0; tick();
        rx_valid = 0;
        total++; if (state !== P_XCHG || tx_valid !== 1'b1 || tx_msg !== M_RESP) begin
            bad++; $display("FAIL abort_setup got state=%0d valid=%b msg=%b exp 2/1/010", state, tx_valid, tx_msg);
        end
        tick();
        start = 0; tick();
        total++; if (state !== P_IDLE || tx_valid !== 1'b0) begin
            bad++; $display("FAIL abort_start got state=%0d valid=%b exp 0/0", state, tx_valid);
        end
        tick();
        start = 1; tx_ready = 1;
        tick(); tick();
        rx_pulse(M_OOR); tx_ready = 0; tick();
        rx_valid = 0;
        total++; if (tx_valid !== 1'b1 || tx_msg !== M_REQ) begin
            bad++; $display("FAIL abort_flags_cleared got valid=%b msg=%b exp 1/001", tx_valid, tx_msg);
        end
        rst_n = 0; tick();
        total++; if (dut_vec() !== 9'h000 || tx_msg !== 3'b000) begin
            bad++; $display("FAIL abort_reset got=%h msg=%b exp=000 msg=000", dut_vec(), tx_msg);
        end
        rst_n = 1; start = 0; tick();
    endtask

    task automatic test_timeout();
        start = 1; tx_ready = 1;
        tick();
        for (int i = 1; i < TMO; i++) begin
            tick();
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL tmo_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        total++; if (error !== 1'b1 || state !== P_ERR) begin
            bad++; $display("FAIL tmo_error got err=%b state=%0d exp err=1 state=4", error, state);
        end
        start = 0; tick();
        total++; if (error !== 1'b0 || state !== P_IDLE) begin
            bad++; $display("FAIL tmo_clear got err=%b state=%0d exp err=0 state=0", error, state);
        end
    endtask

    task automatic test_no_timeout();
        start = 1; tx_ready = 1;
        for (int i = 0; i < 300; i++) tick();
        total++; if (error !== 1'b0 || state !== P_OOR) begin
            bad++; $display("FAIL no_tmo got err=%b state=%0d exp err=0 state=1", error, state);
        end
        start = 0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if (!start) start = ($urandom_range(0, 5) == 0);
            else if ($urandom_range(0, 199) == 0) start = 0;
            rst_n    = ($urandom_range(0, 999) != 0);
            tx_ready = ($urandom_range(0, 9) < 6);
            rx_valid = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 5))
                0, 1:    rx_msg = M_OOR;
                2:       rx_msg = M_REQ;
                3:       rx_msg = M_RESP;
                4:       rx_msg = 3'b111;
                default: rx_msg = 3'($urandom_range(3, 6));
            endcase
            tick();
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        rst_n = 1; rx_valid = 0; start = 0; tick();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_happy();
        test_resend();
        test_backpressure();
        test_ordering();
        test_abort();
        if (TMO_EN) test_timeout();
        else        test_no_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
